// File: rtl/ifetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_queue_pkg
// Description : Shared types and helpers for the instruction-fetch queue.
//               Holds the default queue-entry layout and the width rule for
//               occupancy counters.
// Revision    : 1.0 - initial release
// ============================================================================
package ifetch_queue_pkg;

    localparam int c_def_addr_bits  = 32;
    localparam int c_def_data_width = 32;

    // One queue entry at the default widths: fetched instruction and its PC.
    typedef struct packed {
        logic [c_def_data_width-1:0] instr;
        logic [c_def_addr_bits-1:0]  pc;
    } ifq_entry_t;

    // Width needed to hold a count of 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Circular buffer of fetched instructions with push, pop,
//               flush and an entry count. Head is read straight from the
//               registered storage at the registered read pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import ifetch_queue_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type ENTRY_T = ifq_entry_t
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_push,
    input  ENTRY_T                       i_push_entry,
    input  logic                         i_pop,
    input  logic                         i_flush,
    output ENTRY_T                       o_head,
    output logic [occ_width(DEPTH)-1:0]  o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = occ_width(DEPTH);

    ENTRY_T               r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_cnt_w-1:0]   r_count;

    // Entry storage needs no reset; contents are only observed when counted.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (!i_push && i_pop) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_queue
// Description : Instruction-fetch stage with a prefetch queue. Issues one
//               memory read per cycle while a queue slot is guaranteed for
//               it, buffers returned instructions with their PC, and hands
//               them to decode through valid/ready. A branch redirects the
//               PC, flushes the queue and discards any in-flight response.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int                   ADDR_BITS  = 32,
    parameter int                   DATA_WIDTH = 32,
    parameter int                   DEPTH      = 4,
    parameter logic [ADDR_BITS-1:0] PC_INC     = ADDR_BITS'(1),
    parameter logic [ADDR_BITS-1:0] RESET_PC   = '0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         fetch_enable,
    input  logic                         branch,
    input  logic [ADDR_BITS-1:0]         branch_pc_in,
    output logic                         imem_req,
    output logic [ADDR_BITS-1:0]         imem_addr,
    input  logic [DATA_WIDTH-1:0]        imem_rdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        instr_out,
    output logic [ADDR_BITS-1:0]         pc_out,
    output logic [ADDR_BITS-1:0]         next_pc_out,
    output logic [occ_width(DEPTH)-1:0]  occupancy
);

    localparam int                  c_cnt_w  = occ_width(DEPTH);
    localparam int                  c_free_w = c_cnt_w + 1;
    localparam logic [c_cnt_w-1:0]  c_depth  = c_cnt_w'(DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [ADDR_BITS-1:0]  pc;
    } entry_t;

    logic [ADDR_BITS-1:0]  r_pc;
    logic                  r_inflight;
    logic [ADDR_BITS-1:0]  r_inflight_pc;
    logic                  r_drop;

    logic                  w_out_valid;
    logic                  w_pop;
    logic                  w_push;
    logic [c_free_w-1:0]   w_free;
    logic                  w_req;
    logic [c_cnt_w-1:0]    w_count;
    entry_t                w_head;
    entry_t                w_push_entry;

    // Handshake and credit: a request is only issued when the slot its
    // response will need next cycle is already accounted for.
    always_comb begin
        w_out_valid  = (w_count != '0);
        w_pop        = w_out_valid & out_ready & ~branch;
        w_push       = r_inflight & ~r_drop & ~branch;
        w_free       = {1'b0, c_depth} - {1'b0, w_count}
                     - c_free_w'(r_inflight) + c_free_w'(w_pop);
        w_req        = reset_n & fetch_enable & ~branch & (w_free != '0);
        w_push_entry = '{instr: imem_rdata, pc: r_inflight_pc};
    end

    // PC, in-flight tracking and stale-response drop flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_drop        <= 1'b0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_inflight_pc <= r_pc;
                r_pc          <= r_pc + PC_INC;
            end
            if (branch) begin
                r_pc   <= branch_pc_in;
                // A read still outstanding after the redirect would be stale.
                r_drop <= w_req;
            end else if (r_inflight && r_drop) begin
                r_drop <= 1'b0;
            end
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_T (entry_t)
    ) u_fifo (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_flush      (branch),
        .o_head       (w_head),
        .o_count      (w_count)
    );

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign out_valid   = w_out_valid;
    assign instr_out   = w_head.instr;
    assign pc_out      = w_head.pc;
    assign next_pc_out = w_head.pc + PC_INC;
    assign occupancy   = w_count;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_queue
// Description : Self-checking bench for ifetch_queue. A queue-based model of
//               the fetch stage predicts every output each cycle; directed
//               literal checks pin reset, latency, stall, redirect and PC wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ifetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_enable;
    logic        branch;
    logic [31:0] branch_pc_in;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] next_pc_out;
    logic [2:0]  occupancy;

    logic        wrap_req;
    logic [31:0] wrap_addr;
    logic [31:0] wrap_rdata;
    logic        wrap_valid;
    logic [31:0] wrap_instr;
    logic [31:0] wrap_pc;
    logic [31:0] wrap_next_pc;
    logic [2:0]  wrap_occ;

    always #5 clk = ~clk;

    ifetch_queue #(
        .ADDR_BITS(32), .DATA_WIDTH(32), .DEPTH(DEPTH),
        .PC_INC(32'd1), .RESET_PC(32'd0)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .fetch_enable(fetch_enable),
        .branch(branch), .branch_pc_in(branch_pc_in),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .instr_out(instr_out),
        .pc_out(pc_out), .next_pc_out(next_pc_out), .occupancy(occupancy)
    );

    ifetch_queue #(
        .ADDR_BITS(32), .DATA_WIDTH(32), .DEPTH(DEPTH),
        .PC_INC(32'd1), .RESET_PC(32'hFFFF_FFFE)
    ) u_wrap (
        .clk(clk), .reset_n(reset_n), .fetch_enable(1'b1),
        .branch(1'b0), .branch_pc_in(32'd0),
        .imem_req(wrap_req), .imem_addr(wrap_addr), .imem_rdata(wrap_rdata),
        .out_valid(wrap_valid), .out_ready(1'b1), .instr_out(wrap_instr),
        .pc_out(wrap_pc), .next_pc_out(wrap_next_pc), .occupancy(wrap_occ)
    );

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return 32'h1000 + a;
    endfunction

    // Synchronous instruction memories; junk is driven when nothing was read.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? mem_f(imem_addr) : $urandom();
        wrap_rdata <= wrap_req ? mem_f(wrap_addr) : $urandom();
    end

    // Reference model state
    logic [63:0] mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_ipc;
    bit          m_inflight;

    int          n_vec;
    int          n_err;
    logic        last_req;
    logic [31:0] last_addr;
    int          wrap_idx;
    logic [31:0] wrap_exp [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc       = 32'd0;
        m_ipc      = 32'd0;
        m_inflight = 1'b0;
    endtask

    // Drive one cycle of inputs at the falling edge, check, advance the model.
    task automatic step(input bit fe, input bit br, input logic [31:0] bpc, input bit rdy);
        bit          ev;
        bit          pop;
        bit          er;
        int          free;
        logic [63:0] hd;
        logic [31:0] enp;
        fetch_enable = fe;
        branch       = br;
        branch_pc_in = bpc;
        out_ready    = rdy;
        #1;
        ev   = (mq.size() != 0);
        pop  = ev && rdy && !br;
        free = DEPTH - mq.size() - int'(m_inflight) + int'(pop);
        er   = fe && !br && (free > 0);
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("occupancy", 64'(occupancy), 64'(mq.size()));
        chk("imem_req", 64'(imem_req), 64'(er));
        chk("imem_addr", 64'(imem_addr), 64'(m_pc));
        if (ev) begin
            hd  = mq[0];
            enp = hd[31:0] + 32'd1;
            chk("instr_out", 64'(instr_out), 64'(hd[63:32]));
            chk("pc_out", 64'(pc_out), 64'(hd[31:0]));
            chk("next_pc_out", 64'(next_pc_out), 64'(enp));
        end
        last_req  = imem_req;
        last_addr = imem_addr;
        if (wrap_idx < 4 && wrap_valid) begin
            chk("wrap_pc", 64'(wrap_pc), 64'(wrap_exp[wrap_idx]));
            chk("wrap_instr", 64'(wrap_instr), 64'(mem_f(wrap_exp[wrap_idx])));
            if (wrap_idx == 1) chk("wrap_next_pc", 64'(wrap_next_pc), 64'd0);
            wrap_idx++;
        end
        if (br) begin
            mq.delete();
            m_pc       = bpc;
            m_inflight = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_inflight) mq.push_back({mem_f(m_ipc), m_ipc});
            if (er) begin
                m_ipc = m_pc;
                m_pc  = m_pc + 32'd1;
            end
            m_inflight = er;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        wrap_exp[0] = 32'hFFFF_FFFE;
        wrap_exp[1] = 32'hFFFF_FFFF;
        wrap_exp[2] = 32'h0000_0000;
        wrap_exp[3] = 32'h0000_0001;
        wrap_idx     = 4;
        reset_n      = 1'b0;
        fetch_enable = 1'b1;
        branch       = 1'b0;
        branch_pc_in = 32'd0;
        out_ready    = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_imem_req", 64'(imem_req), 64'd0);
        chk("rst_wrap_req", 64'(wrap_req), 64'd0);
        reset_n  = 1'b1;
        wrap_idx = 0;

        // Start-up latency and streaming
        step(1, 0, 32'd0, 1);
        chk("lat_valid_early", 64'(out_valid), 64'd0);
        step(1, 0, 32'd0, 1);
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("lat_pc", 64'(pc_out), 64'd0);
        chk("lat_instr", 64'(instr_out), 64'h1000);
        chk("lat_next_pc", 64'(next_pc_out), 64'd1);
        step(1, 0, 32'd0, 1);
        chk("stream_pc1", 64'(pc_out), 64'd1);
        repeat (5) step(1, 0, 32'd0, 1);

        // Back-pressure: queue fills and requests stop
        repeat (10) step(1, 0, 32'd0, 0);
        chk("stall_occ", 64'(occupancy), 64'd4);
        chk("stall_pc", 64'(pc_out), 64'd6);
        chk("stall_instr", 64'(instr_out), 64'h1006);
        chk("stall_req", 64'(last_req), 64'd0);

        // One pop leaves 3 queued with a read in flight
        step(1, 0, 32'd0, 1);
        chk("pre_br_occ", 64'(occupancy), 64'd3);
        chk("pre_br_req", 64'(last_req), 64'd1);

        // Redirect together with a pop
        step(1, 1, 32'h40, 1);
        chk("br_occ", 64'(occupancy), 64'd0);
        step(1, 0, 32'd0, 1);
        chk("br_req", 64'(last_req), 64'd1);
        chk("br_addr", 64'(last_addr), 64'h40);
        chk("br_valid_gap", 64'(out_valid), 64'd0);
        step(1, 0, 32'd0, 1);
        chk("br_head_valid", 64'(out_valid), 64'd1);
        chk("br_head_pc", 64'(pc_out), 64'h40);
        chk("br_head_instr", 64'(instr_out), 64'h1040);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0),
                 $urandom(), ($urandom_range(0, 9) < 7));
        end

        // Asynchronous reset mid-stream with a read outstanding
        repeat (3) step(1, 0, 32'd0, 1);
        chk("mid_pre_req", 64'(last_req), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_occ", 64'(occupancy), 64'd0);
        chk("mid_rst_req", 64'(imem_req), 64'd0);
        model_reset();
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset_n  = 1'b1;
        wrap_idx = 0;
        step(1, 0, 32'd0, 1);
        chk("mid_first_req", 64'(last_req), 64'd1);
        chk("mid_first_addr", 64'(last_addr), 64'd0);
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0),
                 $urandom(), ($urandom_range(0, 9) < 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifetch_queue.md
# ifetch_queue

Parametrised instruction-fetch stage with a prefetch queue. Keeps the program counter, issues one instruction-memory read per cycle while queue space exists, and buffers returned instructions with their PC and next-PC. Decode consumes entries through a valid/ready handshake. A branch redirect flushes the queue and discards the in-flight read. Sits between the synchronous instruction memory and the decode stage.

## Interface
- ADDR_BITS, 32, PC and memory address width
- DATA_WIDTH, 32, instruction width
- DEPTH, 4, queue entries; power of two, ≥ 2
- PC_INC, 1, PC increment per sequential fetch
- RESET_PC, 0, PC value after reset
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- fetch_enable  in  1  permits new memory requests; in-flight reads still complete
- branch  in  1  redirect request, one-cycle pulse
- branch_pc_in  in  ADDR_BITS  redirect target
- imem_req  out  1  read strobe to instruction memory
- imem_addr  out  ADDR_BITS  read address (equals current PC)
- imem_rdata  in  DATA_WIDTH  read data, valid exactly 1 cycle after imem_req
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- instr_out  out  DATA_WIDTH  head instruction
- pc_out  out  ADDR_BITS  head PC
- next_pc_out  out  ADDR_BITS  head PC + PC_INC
- occupancy  out  $clog2(DEPTH)+1  entries currently held

## Operation
- State: pc, inflight flag, inflight_pc, drop flag, queue (count, rd/wr pointers, DEPTH entries of {instr, pc}).
- pop = out_valid & out_ready & ~branch.
- free = DEPTH − count − inflight + pop.
- imem_req = fetch_enable & ~branch & (free > 0). imem_addr = pc.
- On an imem_req cycle: inflight_pc ← pc, inflight ← 1, and pc ← pc + PC_INC (mod 2^ADDR_BITS). With no request, inflight ← 0.
- Response cycle (inflight = 1): if drop = 0, push {imem_rdata, inflight_pc}. If drop = 1, discard the data and clear drop.
- branch: pc ← branch_pc_in, queue flushed (count ← 0, pointers ← 0), no request and no pop that cycle. If a read is issued-but-unreturned (inflight = 1 at the next edge's view), drop ← 1 so that its response is discarded. A response arriving in the branch cycle itself is discarded.
- Branch has priority over pop, push and request in the same cycle.
- Queue never overflows. The credit rule guarantees a slot for every in-flight read. Push and pop in the same cycle leave count unchanged.
- next_pc_out is combinational from the head pc (+ PC_INC, wrapping).
- fetch_enable low: pc holds, and any outstanding response is still pushed.

## Timing
- Reset (asynchronous, reset_n = 0): pc = RESET_PC, count = 0, inflight = 0, drop = 0, out_valid = 0, imem_req = 0 while in reset, occupancy = 0. instr_out, pc_out and next_pc_out are don't-care while out_valid = 0.
- Reset is effective mid-operation: in-flight data is lost and the first request after deassertion is at RESET_PC.
- Fetch latency: request in cycle c → imem_rdata in c+1 → out_valid in c+2.
- Sustained throughput: 1 instruction per cycle when out_ready = 1 and DEPTH ≥ 2.
- Redirect latency: branch in cycle t → request to branch_pc_in in t+1 → target at the queue head in t+3.
- out_valid and the head fields are registered (queue outputs); no combinational path from imem_rdata to the outputs.
- Head fields are stable while out_valid = 1 and out_ready = 0.

## Structure
- Shared package: ifetch entry struct {instr, pc} and the occupancy-width function.
- One sub-module, fetch_fifo: a DEPTH × (DATA_WIDTH + ADDR_BITS) circular buffer with push, pop, flush and count.
- PC, credit and drop logic live in ifetch_queue.

## Test plan
- Reset release with out_ready = 1, fetch_enable = 1 and memory returning mem[a] = 0x1000+a → out_valid first in cycle 3, head stream pc = 0,1,2,3…, instr 0x1000,0x1001…, one per cycle, next_pc_out = pc+1.
- out_ready held 0 for 10 cycles with DEPTH = 4 → imem_req stops after 4 requests, occupancy = 4, no entry lost. out_ready released → the 4 entries drain in order, then streaming resumes at pc 4.
- branch with branch_pc_in = 0x40 while a read is in flight and the queue is at 3 → queue empties, the stale response is never output, request at 0x40 in t+1, head pc = 0x40 in t+3.
- branch and pop asserted in the same cycle → the head is not consumed (flush), and the next valid head is the branch target.
- Wrap: RESET_PC = 0xFFFFFFFE, PC_INC = 1 → pc sequence FFFFFFFE, FFFFFFFF, 0, 1, and next_pc_out for FFFFFFFF is 0.
- reset_n pulsed low mid-stream with an outstanding read → all outputs return to reset values immediately, and the next fetch after release is at RESET_PC.
